// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential divider.
// Holds the FSM state encoding, the default operand width and a
// conditional two's-complement negate used by div_sign_mag.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    localparam int DIV_W_DEFAULT = 32;

    // Widest operand the negate helper supports; narrower callers
    // zero-extend in and truncate out, which is exact modulo 2^W.
    localparam int DIV_W_MAX = 64;

    function automatic logic [DIV_W_MAX-1:0] cond_neg(input logic [DIV_W_MAX-1:0] val,
                                                      input logic neg);
        return neg ? (~val + DIV_W_MAX'(1)) : val;
    endfunction

endpackage

// File: rtl/div_seq_param_if.sv
// Request/result bundle between the control unit (master) and the
// divider (slave).
interface div_seq_param_if
    import div_pkg::*;
#(
    parameter int W = DIV_W_DEFAULT
);
    logic         start;
    logic         abort;
    logic         is_signed;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;
    logic         divzero;
    logic         overflow;

    modport master (
        output start, abort, is_signed, a, b,
        input  hi, lo, busy, done, divzero, overflow
    );

    modport slave (
        input  start, abort, is_signed, a, b,
        output hi, lo, busy, done, divzero, overflow
    );
endinterface

// File: rtl/div_sign_mag.sv
// Combinational conditional negate: res = neg ? -val : val.
// Used both to take operand magnitudes and to restore result signs.
module div_sign_mag
    import div_pkg::*;
#(
    parameter int W = DIV_W_DEFAULT
) (
    input  logic [W-1:0] val,
    input  logic         neg,
    output logic [W-1:0] res
);
    assign res = W'(cond_neg(DIV_W_MAX'(val), neg));
endmodule

// File: rtl/div_seq_param.sv
// Multi-cycle restoring divider, one quotient bit per clock.
// hi = remainder, lo = quotient, truncating toward zero.
// Build option: define DIV_EARLY_OUT_EN to skip the iteration phase
// when |a| < |b| (result is then known to be q=0, r=|a|).
module div_seq_param
    import div_pkg::*;
#(
    parameter  int W  = DIV_W_DEFAULT,
    localparam int CW = $clog2(W + 1),
    localparam int IW = $clog2(W)
) (
    input logic            clk,
    input logic            rst,
    div_seq_param_if.slave bus
);
    state_t         state, state_next;
    logic [W-1:0]   n, n_next, d, d_next;
    logic [W-1:0]   q, q_next, r, r_next;
    logic [W-1:0]   hi, hi_next, lo, lo_next;
    logic [CW-1:0]  cnt, cnt_next;
    logic           qneg, qneg_next, rneg, rneg_next, sgn, sgn_next;
    logic           done, done_next, divzero, divzero_next, overflow, overflow_next;
    logic [W-1:0]   abs_a, abs_b, q_fix, r_fix;
    logic           a_neg, b_neg;
    // Partial remainder is one bit wider than W so that large unsigned
    // divisors (MSB set) never lose the shifted-out remainder bit.
    logic [W:0]     p, diff;

    assign a_neg = bus.is_signed & bus.a[W-1];
    assign b_neg = bus.is_signed & bus.b[W-1];

    div_sign_mag #(.W(W)) u_abs_a (.val(bus.a), .neg(a_neg), .res(abs_a));
    div_sign_mag #(.W(W)) u_abs_b (.val(bus.b), .neg(b_neg), .res(abs_b));
    div_sign_mag #(.W(W)) u_fix_q (.val(q),     .neg(qneg),  .res(q_fix));
    div_sign_mag #(.W(W)) u_fix_r (.val(r),     .neg(rneg),  .res(r_fix));

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Datapath and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            n        <= '0;
            d        <= '0;
            q        <= '0;
            r        <= '0;
            hi       <= '0;
            lo       <= '0;
            cnt      <= '0;
            qneg     <= 1'b0;
            rneg     <= 1'b0;
            sgn      <= 1'b0;
            done     <= 1'b0;
            divzero  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            n        <= n_next;
            d        <= d_next;
            q        <= q_next;
            r        <= r_next;
            hi       <= hi_next;
            lo       <= lo_next;
            cnt      <= cnt_next;
            qneg     <= qneg_next;
            rneg     <= rneg_next;
            sgn      <= sgn_next;
            done     <= done_next;
            divzero  <= divzero_next;
            overflow <= overflow_next;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_next    = state;
        n_next        = n;
        d_next        = d;
        q_next        = q;
        r_next        = r;
        hi_next       = hi;
        lo_next       = lo;
        cnt_next      = cnt;
        qneg_next     = qneg;
        rneg_next     = rneg;
        sgn_next      = sgn;
        done_next     = 1'b0;
        divzero_next  = divzero;
        overflow_next = overflow;
        p             = '0;
        diff          = '0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.b == '0) begin
                        divzero_next  = 1'b1;
                        overflow_next = 1'b0;
                        hi_next       = '0;
                        lo_next       = '0;
                        done_next     = 1'b1;
                    end else begin
                        divzero_next  = 1'b0;
                        overflow_next = 1'b0;
                        n_next        = abs_a;
                        d_next        = abs_b;
                        qneg_next     = a_neg ^ b_neg;
                        rneg_next     = a_neg;
                        sgn_next      = bus.is_signed;
                        q_next        = '0;
                        r_next        = '0;
                        cnt_next      = CW'(W - 1);
                        state_next    = CALC;
`ifdef DIV_EARLY_OUT_EN
                        if (abs_a < abs_b) begin
                            r_next     = abs_a;
                            state_next = FIX;
                        end
`endif
                    end
                end
            end
            CALC: begin
                if (bus.abort) begin
                    state_next = IDLE;
                end else begin
                    p    = {r, n[cnt[IW-1:0]]};
                    diff = p - {1'b0, d};
                    if (p >= {1'b0, d}) begin
                        r_next                 = diff[W-1:0];
                        q_next[cnt[IW-1:0]]    = 1'b1;
                    end else begin
                        r_next = p[W-1:0];
                    end
                    cnt_next = cnt - CW'(1);
                    if (cnt == '0) state_next = FIX;
                end
            end
            FIX: begin
                if (bus.abort) begin
                    state_next = IDLE;
                end else begin
                    lo_next    = q_fix;
                    hi_next    = r_fix;
                    done_next  = 1'b1;
                    // Only MIN / -1 yields a positive quotient magnitude of 2^(W-1).
                    overflow_next = overflow | (sgn & ~qneg & q[W-1]);
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.hi       = hi;
    assign bus.lo       = lo;
    assign bus.busy     = (state != IDLE);
    assign bus.done     = done;
    assign bus.divzero  = divzero;
    assign bus.overflow = overflow;
endmodule

// File: tb/tb_div_seq_param.sv
// Directed self-checking bench for div_seq_param at W=32.
// Build option DIV_EARLY_OUT_EN adds the early-out scenario and changes
// expected latency for small-dividend cases.
module tb_div_seq_param;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div_seq_param_if #(.W(W)) bus ();
    div_seq_param #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one division and waits (bounded) for done.
    // lat = edges after the start edge until done is seen (0 = same edge).
    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                          output int lat, output logic busy0);
        bus.a = a; bus.b = b; bus.is_signed = sgn; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        busy0 = bus.busy;
        lat = 0;
        while (!bus.done && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0; bus.abort = 1'b0; bus.is_signed = 1'b0;
        bus.a = '0; bus.b = '0;
        tick(); tick();
        total_cnt++;
        if ({bus.hi, bus.lo} !== 64'h0)
            $display("FAIL reset_hilo: got %h expected 0", {bus.hi, bus.lo});
        else pass_cnt++;
        total_cnt++;
        if ({bus.busy, bus.done, bus.divzero, bus.overflow} !== 4'b0000)
            $display("FAIL reset_flags: got %b expected 0000",
                     {bus.busy, bus.done, bus.divzero, bus.overflow});
        else pass_cnt++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_unsigned();
        int lat; logic busy0;
        do_div(32'd100, 32'd7, 1'b0, lat, busy0);
        total_cnt++;
        if (busy0 !== 1'b1) $display("FAIL unsigned_busy: got %b expected 1", busy0);
        else pass_cnt++;
        total_cnt++;
`ifdef DIV_EARLY_OUT_EN
        if (lat !== 33) $display("FAIL unsigned_lat: got %0d expected 33", lat);
`else
        if (lat !== 33) $display("FAIL unsigned_lat: got %0d expected 33", lat);
`endif
        else pass_cnt++;
        total_cnt++;
        if ({bus.lo, bus.hi} !== {32'd14, 32'd2})
            $display("FAIL unsigned_res: got lo=%0d hi=%0d expected lo=14 hi=2", bus.lo, bus.hi);
        else pass_cnt++;
        total_cnt++;
        if ({bus.busy, bus.divzero, bus.overflow} !== 3'b000)
            $display("FAIL unsigned_flags: got %b expected 000", {bus.busy, bus.divzero, bus.overflow});
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.done !== 1'b0) $display("FAIL done_pulse: got %b expected 0", bus.done);
        else pass_cnt++;
        // Divisor with MSB set exercises the full-width partial remainder.
        do_div(32'hFFFF_FFFF, 32'h8000_0001, 1'b0, lat, busy0);
        total_cnt++;
        if ({bus.lo, bus.hi} !== {32'h1, 32'h7FFF_FFFE})
            $display("FAIL unsigned_bigdiv: got lo=%h hi=%h expected lo=00000001 hi=7ffffffe",
                     bus.lo, bus.hi);
        else pass_cnt++;
    endtask

    task automatic test_signed();
        int lat; logic busy0;
        do_div(32'hFFFF_FFF9, 32'd2, 1'b1, lat, busy0);
        total_cnt++;
        if ({bus.lo, bus.hi} !== {32'hFFFF_FFFD, 32'hFFFF_FFFF})
            $display("FAIL signed_neg_a: got lo=%h hi=%h expected lo=fffffffd hi=ffffffff",
                     bus.lo, bus.hi);
        else pass_cnt++;
        do_div(32'd7, 32'hFFFF_FFFE, 1'b1, lat, busy0);
        total_cnt++;
        if ({bus.lo, bus.hi} !== {32'hFFFF_FFFD, 32'h1})
            $display("FAIL signed_neg_b: got lo=%h hi=%h expected lo=fffffffd hi=00000001",
                     bus.lo, bus.hi);
        else pass_cnt++;
        do_div(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, lat, busy0);
        total_cnt++;
        if ({bus.lo, bus.hi} !== {32'h3, 32'hFFFF_FFFF})
            $display("FAIL signed_neg_both: got lo=%h hi=%h expected lo=00000003 hi=ffffffff",
                     bus.lo, bus.hi);
        else pass_cnt++;
        do_div(32'hFFFF_FFF9, 32'd2, 1'b0, lat, busy0);
        total_cnt++;
        if ({bus.lo, bus.hi} !== {32'h7FFF_FFFC, 32'h1})
            $display("FAIL unsigned_big_a: got lo=%h hi=%h expected lo=7ffffffc hi=00000001",
                     bus.lo, bus.hi);
        else pass_cnt++;
    endtask

    task automatic test_divzero();
        int lat; logic busy0;
        do_div(32'd55, 32'd0, 1'b0, lat, busy0);
        total_cnt++;
        if (lat !== 0) $display("FAIL dz_lat: got %0d expected 0", lat);
        else pass_cnt++;
        total_cnt++;
        if ({busy0, bus.divzero, bus.done} !== 3'b011)
            $display("FAIL dz_flags: got busy/dz/done=%b expected 011", {busy0, bus.divzero, bus.done});
        else pass_cnt++;
        total_cnt++;
        if ({bus.lo, bus.hi} !== 64'h0)
            $display("FAIL dz_res: got %h expected 0", {bus.lo, bus.hi});
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({bus.divzero, bus.done} !== 2'b10)
            $display("FAIL dz_sticky: got dz/done=%b expected 10", {bus.divzero, bus.done});
        else pass_cnt++;
        do_div(32'd9, 32'd3, 1'b0, lat, busy0);
        total_cnt++;
        if ({bus.divzero, bus.lo, bus.hi} !== {1'b0, 32'd3, 32'd0})
            $display("FAIL dz_clear: got dz=%b lo=%0d hi=%0d expected dz=0 lo=3 hi=0",
                     bus.divzero, bus.lo, bus.hi);
        else pass_cnt++;
    endtask

    task automatic test_overflow();
        int lat; logic busy0;
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat, busy0);
        total_cnt++;
        if ({bus.overflow, bus.lo, bus.hi} !== {1'b1, 32'h8000_0000, 32'h0})
            $display("FAIL ovf_set: got ovf=%b lo=%h hi=%h expected ovf=1 lo=80000000 hi=0",
                     bus.overflow, bus.lo, bus.hi);
        else pass_cnt++;
        bus.a = 32'd20; bus.b = 32'd6; bus.is_signed = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        total_cnt++;
        if (bus.overflow !== 1'b0) $display("FAIL ovf_clear: got %b expected 0", bus.overflow);
        else pass_cnt++;
        lat = 0;
        while (!bus.done && lat < 100) begin tick(); lat++; end
        total_cnt++;
        if ({bus.lo, bus.hi} !== {32'd3, 32'd2})
            $display("FAIL ovf_next_res: got lo=%0d hi=%0d expected lo=3 hi=2", bus.lo, bus.hi);
        else pass_cnt++;
        // MIN / 1 is representable and must not flag overflow.
        do_div(32'h8000_0000, 32'd1, 1'b1, lat, busy0);
        total_cnt++;
        if ({bus.overflow, bus.lo, bus.hi} !== {1'b0, 32'h8000_0000, 32'h0})
            $display("FAIL min_div_1: got ovf=%b lo=%h hi=%h expected ovf=0 lo=80000000 hi=0",
                     bus.overflow, bus.lo, bus.hi);
        else pass_cnt++;
        do_div(32'd20, 32'd6, 1'b0, lat, busy0);
    endtask

    task automatic test_abort();
        int seen_done;
        bus.a = 32'd1000; bus.b = 32'd10; bus.is_signed = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        total_cnt++;
        if ({bus.busy, bus.done} !== 2'b00)
            $display("FAIL abort_busy: got busy/done=%b expected 00", {bus.busy, bus.done});
        else pass_cnt++;
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done) seen_done++;
        end
        total_cnt++;
        if (seen_done !== 0) $display("FAIL abort_nodone: got %0d pulses expected 0", seen_done);
        else pass_cnt++;
        total_cnt++;
        if ({bus.lo, bus.hi} !== {32'd3, 32'd2})
            $display("FAIL abort_hold: got lo=%0d hi=%0d expected lo=3 hi=2", bus.lo, bus.hi);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int lat;
        bus.a = 32'd1000; bus.b = 32'd10; bus.is_signed = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        bus.a = 32'd5; bus.b = 32'd1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        lat = 6;
        while (!bus.done && lat < 100) begin tick(); lat++; end
        total_cnt++;
        if (lat !== 33) $display("FAIL ignore_start_lat: got %0d expected 33", lat);
        else pass_cnt++;
        total_cnt++;
        if ({bus.lo, bus.hi} !== {32'd100, 32'd0})
            $display("FAIL ignore_start_res: got lo=%0d hi=%0d expected lo=100 hi=0", bus.lo, bus.hi);
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({bus.busy, bus.done} !== 2'b00)
            $display("FAIL ignore_start_idle: got busy/done=%b expected 00", {bus.busy, bus.done});
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int lat; logic busy0;
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat, busy0);
        bus.a = 32'd100; bus.b = 32'd7; bus.is_signed = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total_cnt++;
        if ({bus.lo, bus.hi, bus.busy, bus.done, bus.divzero, bus.overflow} !== 68'h0)
            $display("FAIL reset_mid: got lo=%h hi=%h flags=%b expected all 0", bus.lo, bus.hi,
                     {bus.busy, bus.done, bus.divzero, bus.overflow});
        else pass_cnt++;
        do_div(32'd100, 32'd7, 1'b0, lat, busy0);
        total_cnt++;
        if ({bus.lo, bus.hi} !== {32'd14, 32'd2})
            $display("FAIL after_reset: got lo=%0d hi=%0d expected lo=14 hi=2", bus.lo, bus.hi);
        else pass_cnt++;
    endtask

`ifdef DIV_EARLY_OUT_EN
    task automatic test_early_out();
        int lat; logic busy0;
        do_div(32'd3, 32'd10, 1'b0, lat, busy0);
        total_cnt++;
        if (lat !== 1) $display("FAIL early_lat: got %0d expected 1", lat);
        else pass_cnt++;
        total_cnt++;
        if ({bus.lo, bus.hi} !== {32'd0, 32'd3})
            $display("FAIL early_res: got lo=%0d hi=%0d expected lo=0 hi=3", bus.lo, bus.hi);
        else pass_cnt++;
        do_div(32'hFFFF_FFFD, 32'd10, 1'b1, lat, busy0);
        total_cnt++;
        if ({lat == 1, bus.lo, bus.hi} !== {1'b1, 32'd0, 32'hFFFF_FFFD})
            $display("FAIL early_signed: got lat=%0d lo=%h hi=%h expected lat=1 lo=0 hi=fffffffd",
                     lat, bus.lo, bus.hi);
        else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_divzero();
        test_overflow();
        test_abort();
        test_back_to_back();
        test_reset_mid();
`ifdef DIV_EARLY_OUT_EN
        test_early_out();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
